// File: rtl/bcd_hex_if.sv
// Bus between a BCD source and the seven-segment display driver.
// load is a one-cycle capture strobe with no backpressure: bcd_in is taken
// on every rising clk edge where load is high, and the display never stalls.
interface bcd_hex_if;
  logic        load;
  logic [11:0] bcd_in;
  logic        blink_en;
  logic [6:0]  HEX2;
  logic [6:0]  HEX1;
  logic [6:0]  HEX0;
  logic        err;
  logic        blink_on;  // debug view of the blink FSM: 1 = ON phase

  modport master (
    output load, bcd_in, blink_en,
    input  HEX2, HEX1, HEX0, err, blink_on
  );

  modport slave (
    input  load, bcd_in, blink_en,
    output HEX2, HEX1, HEX0, err, blink_on
  );
endinterface

// File: rtl/bcd_hex_display.sv
// Holds a 3-digit packed BCD value and drives three active-low 7-segment
// displays with leading-zero blanking, error display and optional blinking.
module bcd_hex_display #(
  parameter int unsigned BLINK_DIV = 25000000,
  parameter bit          BLANK_LZ  = 1'b1
) (
  input logic       clk,
  input logic       reset,
  bcd_hex_if.slave  bus
);

  localparam int unsigned CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {ST_ON = 1'b0, ST_OFF = 1'b1} blink_state_t;

  blink_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   bcd_q;
  logic [3:0]    dig_h, dig_t, dig_o;
  logic          bad;
  logic [6:0]    hex2_d, hex1_d, hex0_d;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_E;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_q <= 12'h000;
    end else if (bus.load) begin
      bcd_q <= bus.bcd_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ON;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Disabling blink parks the FSM in ON with a cleared counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!bus.blink_en) begin
      state_d = ST_ON;
      cnt_d   = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      state_d = (state_q == ST_ON) ? ST_OFF : ST_ON;
    end else begin
      cnt_d   = cnt_q + 1'b1;
    end
  end

  assign dig_h = bcd_q[11:8];
  assign dig_t = bcd_q[7:4];
  assign dig_o = bcd_q[3:0];
  assign bad   = (dig_h > 4'd9) || (dig_t > 4'd9) || (dig_o > 4'd9);

  // Priority: blink-off blanking, then error, then leading-zero blanking.
  always_comb begin
    hex2_d = seg7(dig_h);
    hex1_d = seg7(dig_t);
    hex0_d = seg7(dig_o);
    if (bad) begin
      hex2_d = SEG_E;
      hex1_d = SEG_E;
      hex0_d = SEG_E;
    end else if (BLANK_LZ) begin
      if (dig_h == 4'd0) hex2_d = SEG_BLANK;
      if (dig_h == 4'd0 && dig_t == 4'd0) hex1_d = SEG_BLANK;
    end
    if (bus.blink_en && state_q == ST_OFF) begin
      hex2_d = SEG_BLANK;
      hex1_d = SEG_BLANK;
      hex0_d = SEG_BLANK;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.HEX2 <= SEG_BLANK;
      bus.HEX1 <= SEG_BLANK;
      bus.HEX0 <= SEG_BLANK;
      bus.err  <= 1'b0;
    end else begin
      bus.HEX2 <= hex2_d;
      bus.HEX1 <= hex1_d;
      bus.HEX0 <= hex0_d;
      bus.err  <= bad;
    end
  end

  assign bus.blink_on = (state_q == ST_ON);

endmodule

// File: tb/tb_bcd_hex_display.sv
// Directed bench for bcd_hex_display: two instances (BLANK_LZ = 1 and 0),
// both with BLINK_DIV = 4, checked with immediate assertions.
module tb_bcd_hex_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] BL = 7'b1111111;

  logic clk;
  logic reset;
  int   passed;
  int   total;
  int   failed;

  bcd_hex_if a ();
  bcd_hex_if b ();

  bcd_hex_display #(.BLINK_DIV(4), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bus(a.slave)
  );

  bcd_hex_display #(.BLINK_DIV(4), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bus(b.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [6:0] e2, input logic [6:0] e1,
                       input logic [6:0] e0, input logic ee);
    chk({tag, ".HEX2"}, 32'(a.HEX2), 32'(e2));
    chk({tag, ".HEX1"}, 32'(a.HEX1), 32'(e1));
    chk({tag, ".HEX0"}, 32'(a.HEX0), 32'(e0));
    chk({tag, ".err"},  32'(a.err),  32'(ee));
  endtask

  task automatic load_a(input logic [11:0] v);
    a.load   = 1'b1;
    a.bcd_in = v;
    step();
    a.load   = 1'b0;
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    failed     = 0;
    reset      = 1'b1;
    a.load     = 1'b0;
    a.bcd_in   = 12'h000;
    a.blink_en = 1'b0;
    b.load     = 1'b0;
    b.bcd_in   = 12'h000;
    b.blink_en = 1'b0;
    #1;
    chk_a("por", BL, BL, BL, 1'b0);
    #22;
    reset = 1'b0;
    step();

    // load sweep with leading-zero blanking
    load_a(12'h000);
    step();
    chk_a("ld000", BL, BL, S0, 1'b0);
    load_a(12'h064);
    chk_a("ld064_latency", BL, BL, S0, 1'b0);
    step();
    chk_a("ld064", BL, S6, S4, 1'b0);
    load_a(12'h255);
    step();
    chk_a("ld255", S2, S5, S5, 1'b0);

    // back-to-back loads: internal zero, then an invalid nibble
    a.load   = 1'b1;
    a.bcd_in = 12'h108;
    step();
    a.bcd_in = 12'h0A3;
    step();
    chk_a("ld108", S1, S0, S8, 1'b0);
    a.load = 1'b0;
    step();
    chk_a("err0A3", SE, SE, SE, 1'b1);
    load_a(12'h012);
    step();
    chk_a("clr012", BL, S1, S2, 1'b0);

    // no leading-zero blanking
    b.load   = 1'b1;
    b.bcd_in = 12'h007;
    step();
    b.load   = 1'b0;
    step();
    chk("nolz007.HEX2", 32'(b.HEX2), 32'(S0));
    chk("nolz007.HEX1", 32'(b.HEX1), 32'(S0));
    chk("nolz007.HEX0", 32'(b.HEX0), 32'(S7));

    // asynchronous reset mid-cycle while showing 255
    load_a(12'h255);
    step();
    chk_a("pre_rst", S2, S5, S5, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_a("async_rst", BL, BL, BL, 1'b0);
    step();
    step();
    #2;
    reset = 1'b0;
    step();
    load_a(12'h012);
    step();
    chk_a("post_rst_ld", BL, S1, S2, 1'b0);

    // blink: 4 edges shown, 4 edges blank
    load_a(12'h128);
    step();
    chk_a("ld128", S1, S2, S8, 1'b0);
    a.blink_en = 1'b1;
    for (int k = 0; k < 14; k++) begin
      step();
      if (((k / 4) % 2) == 0) chk_a($sformatf("blink_on%0d", k), S1, S2, S8, 1'b0);
      else                    chk_a($sformatf("blink_off%0d", k), BL, BL, BL, 1'b0);
    end
    a.blink_en = 1'b0;
    step();
    step();
    chk_a("blink_drop", S1, S2, S8, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk_a($sformatf("blink_stay%0d", k), S1, S2, S8, 1'b0);
    end

    // hold: bcd_in wiggles with load low
    for (int k = 0; k < 20; k++) begin
      a.bcd_in = 12'($urandom_range(0, 4095));
      step();
      chk_a($sformatf("hold%0d", k), S1, S2, S8, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
